// File: rtl/cest_pkg.sv
// cest_pkg: shared constants and arithmetic helpers for the preamble channel estimator
package cest_pkg;
    localparam int DW = 12;
    localparam int N_SC = 512;
    localparam int N_SYM = 6;
    localparam int KW = 9;
    localparam int SW = 3;
    localparam int AW = 15;
    localparam int PW = 36;
    localparam int SHW = 33;
    localparam int MW = 28;
    localparam int QW = 48;
    localparam logic signed [12:0] RECIP6 = 13'sd2731;
    localparam int RECIP_SHIFT = 14;
    localparam logic [11:0] RECIP5 = 12'd3277;
    localparam int SIGMA_SHIFT = 33;

    function automatic logic signed [DW-1:0] round_sat_h(input logic signed [MW-1:0] m);
        logic signed [MW-1:0] r;
        r = (m + MW'(1 << (RECIP_SHIFT - 1))) >>> RECIP_SHIFT;
        return (r > MW'(2047)) ? 12'sd2047 : (r < -MW'(2048)) ? -12'sd2048 : r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_sigma(input logic [QW-1:0] m);
        logic [QW-SIGMA_SHIFT-1:0] q;
        q = m[QW-1:SIGMA_SHIFT];
        return (q > (QW-SIGMA_SHIFT)'(4095)) ? 12'hfff : q[DW-1:0];
    endfunction

    function automatic logic [2*DW-1:0] mag2(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] aa, bb;
        aa = (2*DW)'(a) * (2*DW)'(a);
        bb = (2*DW)'(b) * (2*DW)'(b);
        return aa + bb;
    endfunction
endpackage

// File: rtl/cest_acc_ram.sv
// cest_acc_ram: 512 x 30 simple dual-port accumulator RAM with registered read
module cest_acc_ram
    import cest_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [KW-1:0]   waddr,
    input  logic [2*AW-1:0] wdata,
    input  logic [KW-1:0]   raddr,
    output logic [2*AW-1:0] rdata
);
    logic [2*AW-1:0] mem [N_SC];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cest.sv
// cest: preamble channel estimator, averages 6 symbols per subcarrier and estimates noise variance
module cest
    import cest_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic                 di_vld,
    output logic signed [DW-1:0] H_estimated_re,
    output logic signed [DW-1:0] H_estimated_im,
    output logic                 H_estimated_vld,
    output logic [DW-1:0]        sigma2,
    output logic                 sigma2_vld
);
    logic [KW-1:0] k, k1;
    logic [SW-1:0] s, s1;
    logic v1, v2, v3, last1, last2, last3;
    logic signed [DW-1:0] y1_re, y1_im, h_re, h_im;
    logic signed [AW-1:0] acc_re, acc_im, sum_re, sum_im, s2_re, s2_im;
    logic signed [MW-1:0] m_re, m_im;
    logic [2*AW-1:0] rdata;
    logic [PW-1:0] p_acc, p_snap, nn, sh6;
    logic [SHW-1:0] sh_acc, sh_snap;
    logic [QW-1:0] nn_m;
    logic [DW-1:0] sig_r;
    logic [3:0] g;

    assign acc_re = (s1 == '0) ? '0 : rdata[2*AW-1:AW];
    assign acc_im = (s1 == '0) ? '0 : rdata[AW-1:0];
    assign sum_re = acc_re + AW'(y1_re);
    assign sum_im = acc_im + AW'(y1_im);
    assign h_re = round_sat_h(m_re);
    assign h_im = round_sat_h(m_im);
    assign sh6 = PW'(sh_snap) * 36'd6;

    // The last symbol's sum goes straight to the divider and is never written back
    cest_acc_ram u_ram (
        .clk(clk),
        .we(v1 && s1 != SW'(N_SYM - 1)),
        .waddr(k1),
        .wdata({sum_re, sum_im}),
        .raddr(k),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
            s <= '0;
        end else if (di_vld) begin
            k <= k + 1'b1;
            if (k == KW'(N_SC - 1)) s <= (s == SW'(N_SYM - 1)) ? '0 : s + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {v1, v2, v3, last1, last2, last3} <= '0;
        end else begin
            v1 <= di_vld;
            last1 <= di_vld && s == SW'(N_SYM - 1) && k == KW'(N_SC - 1);
            v2 <= v1 && s1 == SW'(N_SYM - 1);
            last2 <= last1;
            v3 <= v2;
            last3 <= last2;
        end
    end

    always_ff @(posedge clk) begin
        if (di_vld) begin
            y1_re <= di_re;
            y1_im <= di_im;
            k1 <= k;
            s1 <= s;
        end
        if (v1) begin
            s2_re <= sum_re;
            s2_im <= sum_im;
        end
        if (v2) begin
            m_re <= MW'(s2_re) * MW'(RECIP6);
            m_im <= MW'(s2_im) * MW'(RECIP6);
        end
    end

    // Power sums are snapshotted at frame end so the next frame can start accumulating at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {p_acc, p_snap, sh_acc, sh_snap, nn, nn_m, sig_r, g} <= '0;
            {H_estimated_re, H_estimated_im, H_estimated_vld, sigma2, sigma2_vld} <= '0;
        end else begin
            if (v1) p_acc <= last1 ? '0 : p_acc + PW'(mag2(y1_re, y1_im));
            if (last1) p_snap <= p_acc + PW'(mag2(y1_re, y1_im));
            H_estimated_vld <= v3;
            if (v3) begin
                H_estimated_re <= h_re;
                H_estimated_im <= h_im;
                sh_acc <= last3 ? '0 : sh_acc + SHW'(mag2(h_re, h_im));
            end
            if (last3) sh_snap <= sh_acc + SHW'(mag2(h_re, h_im));
            g <= {g[2:0], last3};
            if (g[0]) nn <= (p_snap > sh6) ? p_snap - sh6 : '0;
            if (g[1]) nn_m <= QW'(nn) * QW'(RECIP5);
            if (g[2]) sig_r <= sat_sigma(nn_m);
            sigma2_vld <= g[3];
            if (g[3]) sigma2 <= sig_r;
        end
    end
endmodule

// File: tb/tb_cest.sv
// tb_cest: directed self-checking bench for the preamble channel estimator
module tb_cest;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic di_vld = 1'b0;
    logic [11:0] di_re = '0, di_im = '0;
    logic signed [11:0] H_estimated_re, H_estimated_im;
    logic H_estimated_vld, sigma2_vld;
    logic [11:0] sigma2;
    int pass_n = 0, fail_n = 0, total_n = 0;
    logic [3:0] hv_hist = '0, hl_hist = '0, sv_hist = '0;
    int q_re[$], q_im[$], q_sig[$];

    cest dut (
        .clk(clk),
        .rst(rst),
        .di_re(di_re),
        .di_im(di_im),
        .di_vld(di_vld),
        .H_estimated_re(H_estimated_re),
        .H_estimated_im(H_estimated_im),
        .H_estimated_vld(H_estimated_vld),
        .sigma2(sigma2),
        .sigma2_vld(sigma2_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_h_re"}, int'(H_estimated_re), 0);
        chk({tag, "_h_im"}, int'(H_estimated_im), 0);
        chk({tag, "_h_vld"}, int'(H_estimated_vld), 0);
        chk({tag, "_sigma2"}, int'(sigma2), 0);
        chk({tag, "_sigma2_vld"}, int'(sigma2_vld), 0);
    endtask

    // One cycle: check outputs expected from earlier inputs, then drive the next input
    task automatic cyc(input logic v, input int re, input int im, input logic s5, input logic last,
                       input int ere, input int eim);
        @(negedge clk);
        chk("h_vld", int'(H_estimated_vld), int'(hv_hist[3]));
        if (H_estimated_vld) begin
            chk("h_pending", int'(q_re.size() > 0), 1);
            if (q_re.size() > 0) begin
                chk("h_re", int'(H_estimated_re), q_re.pop_front());
                chk("h_im", int'(H_estimated_im), q_im.pop_front());
            end
        end
        chk("sigma2_vld", int'(sigma2_vld), int'(sv_hist[3]));
        if (sigma2_vld) begin
            chk("sigma2_pending", int'(q_sig.size() > 0), 1);
            if (q_sig.size() > 0) chk("sigma2", int'(sigma2), q_sig.pop_front());
        end
        sv_hist = {sv_hist[2:0], H_estimated_vld & hl_hist[3]};
        hv_hist = {hv_hist[2:0], v & s5};
        hl_hist = {hl_hist[2:0], v & last};
        if (v & s5) begin
            q_re.push_back(ere);
            q_im.push_back(eim);
        end
        di_vld = v;
        di_re = re[11:0];
        di_im = im[11:0];
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    // mode 0: (100,-50); 1: ramp (k-256,0); 2: 264/136 alternating; 3: (2047,-2048)
    task automatic frame(input int mode, input int gap, input int n);
        if (n == 3072) q_sig.push_back(mode == 2 ? 4 : 0);
        for (int i = 0; i < n; i++) begin
            int s, k, re, im, ere, eim;
            s = i / 512;
            k = i % 512;
            case (mode)
                1: begin re = k - 256; im = 0; ere = k - 256; eim = 0; end
                2: begin re = (s % 2 == 0) ? 264 : 136; im = 0; ere = 200; eim = 0; end
                3: begin re = 2047; im = -2048; ere = 2047; eim = -2048; end
                default: begin re = 100; im = -50; ere = 100; eim = -50; end
            endcase
            cyc(1'b1, re, im, s == 5, i == 3071, ere, eim);
            for (int j = 0; j < gap; j++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        frame(0, 0, 3072);
        idle(10);
        frame(1, 0, 3072);
        idle(10);
        frame(2, 0, 3072);
        idle(10);
        chk("sigma2_hold", int'(sigma2), 4);
        frame(3, 0, 3072);
        idle(10);
        frame(0, 1, 3072);
        idle(10);
        frame(0, 0, 1000);
        @(negedge clk);
        rst = 1'b0;
        di_vld = 1'b0;
        #1;
        check_zero("abort");
        repeat (5) @(negedge clk);
        check_zero("abort_hold");
        hv_hist = '0;
        hl_hist = '0;
        sv_hist = '0;
        rst = 1'b1;
        frame(1, 0, 3072);
        frame(2, 0, 3072);
        idle(12);
        chk("h_drained", q_re.size(), 0);
        chk("sigma2_drained", q_sig.size(), 0);
        chk("sigma2_final", int'(sigma2), 4);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
